db_scan_ctrl: RTL and testbench

DB_SCAN_CTRL -- requirements
Module: db_scan_ctrl

---
 rtl/db_scan_ctrl.sv | 165 ++++++++++++++++
 tb/tb_db_scan_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/db_scan_ctrl.sv
// Time-multiplexed switch debouncer: one shared compare/count datapath visits each channel once per sample tick.
// Optional rise/fall edge pulses are built only when DB_SCAN_EVENT_EN is defined.
module db_scan_ctrl #(
   parameter int unsigned N_CH      = 4,
   parameter int unsigned TICK_DIV  = 500000,
   parameter int unsigned REQ_TICKS = 3
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N_CH-1:0] sw,
   output logic [N_CH-1:0] db,
   output logic [N_CH-1:0] rise,
   output logic [N_CH-1:0] fall,
   output logic            m_tick,
   output logic            busy
);

   localparam int unsigned IDX_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int unsigned TICK_W = $clog2(TICK_DIV);
   localparam int unsigned CNT_W  = 3;

   // Parameter legality checked at elaboration
   generate
      if (TICK_DIV < N_CH + 2) begin : g_bad_div
         $error("db_scan_ctrl: TICK_DIV must be >= N_CH+2");
      end
      if (N_CH < 1 || N_CH > 16) begin : g_bad_nch
         $error("db_scan_ctrl: N_CH must be in 1..16");
      end
      if (REQ_TICKS < 1 || REQ_TICKS > 7) begin : g_bad_req
         $error("db_scan_ctrl: REQ_TICKS must be in 1..7");
      end
   endgenerate

   typedef enum logic {IDLE, SCAN} state_t;

   state_t                state, state_nxt;
   logic [IDX_W-1:0]      idx, idx_nxt;
   logic [N_CH-1:0]       sw_m, sw_s;
   logic [TICK_W-1:0]     tcnt;
   logic [CNT_W-1:0]      cnt [N_CH];

   logic                  proc_c;
   logic                  sw_cur_c;
   logic                  db_cur_c;
   logic [CNT_W-1:0]      cnt_inc_c;
   logic [CNT_W-1:0]      cnt_new_c;
   logic                  flip_c;

   // Two-flop synchronizer
   always_ff @(posedge clk) begin
      if (reset) begin
         sw_m <= '0;
         sw_s <= '0;
      end else begin
         sw_m <= sw;
         sw_s <= sw_m;
      end
   end

   // Free-running sample divider; strobe is registered one count early so it lines up with the terminal count
   always_ff @(posedge clk) begin
      if (reset) begin
         tcnt   <= '0;
         m_tick <= 1'b0;
      end else begin
         tcnt   <= (tcnt == TICK_W'(TICK_DIV - 1)) ? '0 : tcnt + TICK_W'(1);
         m_tick <= (tcnt == TICK_W'(TICK_DIV - 2));
      end
   end

   // Scan FSM state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         idx   <= '0;
         busy  <= 1'b0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         busy  <= (state_nxt == SCAN);
      end
   end

   // Scan FSM next state
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      case (state)
         IDLE: begin
            if (m_tick) begin
               state_nxt = SCAN;
               idx_nxt   = '0;
            end
         end
         SCAN: begin
            if (idx == IDX_W'(N_CH - 1)) begin
               state_nxt = IDLE;
               idx_nxt   = '0;
            end else begin
               idx_nxt = idx + IDX_W'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            idx_nxt   = '0;
         end
      endcase
   end

   // Shared compare/count datapath for the channel selected by idx
   always_comb begin
      proc_c    = (state == SCAN);
      sw_cur_c  = sw_s[idx];
      db_cur_c  = db[idx];
      cnt_inc_c = cnt[idx] + CNT_W'(1);
      flip_c    = 1'b0;
      cnt_new_c = '0;
      if (sw_cur_c != db_cur_c) begin
         if (cnt_inc_c == CNT_W'(REQ_TICKS)) begin
            flip_c = proc_c;
         end else begin
            cnt_new_c = cnt_inc_c;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         db <= '0;
         for (int unsigned i = 0; i < N_CH; i++) begin
            cnt[i] <= '0;
         end
      end else if (proc_c) begin
         cnt[idx] <= cnt_new_c;
         if (flip_c) begin
            db[idx] <= sw_cur_c;
         end
      end
   end

`ifdef DB_SCAN_EVENT_EN
   // Edge pulses coincide with the first cycle the new db value is visible
   always_ff @(posedge clk) begin
      if (reset) begin
         rise <= '0;
         fall <= '0;
      end else begin
         rise <= '0;
         fall <= '0;
         if (flip_c) begin
            if (sw_cur_c) begin
               rise[idx] <= 1'b1;
            end else begin
               fall[idx] <= 1'b1;
            end
         end
      end
   end
`else
   assign rise = '0;
   assign fall = '0;
`endif

endmodule

// File: tb/tb_db_scan_ctrl.sv
// Directed bench for db_scan_ctrl with N_CH=4, TICK_DIV=8, REQ_TICKS=3.
// Edge-pulse expectations follow DB_SCAN_EVENT_EN as seen by the bench.
module tb_db_scan_ctrl;

   localparam int unsigned N_CH = 4;

`ifdef DB_SCAN_EVENT_EN
   localparam logic EV = 1'b1;
`else
   localparam logic EV = 1'b0;
`endif

   logic            clk;
   logic            reset;
   logic [N_CH-1:0] sw;
   logic [N_CH-1:0] db, rise, fall;
   logic            m_tick, busy;

   int n_cmp;
   int n_bad;
   logic [N_CH-1:0] ev_acc;

   db_scan_ctrl #(.N_CH(4), .TICK_DIV(8), .REQ_TICKS(3)) dut (
      .clk(clk), .reset(reset), .sw(sw), .db(db),
      .rise(rise), .fall(fall), .m_tick(m_tick), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
      ev_acc = ev_acc | rise | fall;
   endtask

   task automatic steps(input int n);
      repeat (n) step();
   endtask

   task automatic wait_tick();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (m_tick === 1'b1) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      if (!ok) begin
         n_cmp++;
         n_bad++;
         $display("FAIL wait_tick: got no m_tick within 20 cycles, want one");
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      steps(3);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      int n;
      sw = '0;
      do_reset();
      n_cmp++; if (db !== 4'b0000)  begin n_bad++; $display("FAIL rst_db: got %b want 0000", db); end
      n_cmp++; if (rise !== 4'b0000) begin n_bad++; $display("FAIL rst_rise: got %b want 0000", rise); end
      n_cmp++; if (fall !== 4'b0000) begin n_bad++; $display("FAIL rst_fall: got %b want 0000", fall); end
      n_cmp++; if (m_tick !== 1'b0) begin n_bad++; $display("FAIL rst_tick: got %b want 0", m_tick); end
      n_cmp++; if (busy !== 1'b0)   begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
      n = 0;
      while (m_tick !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      n_cmp++; if (n !== 7) begin n_bad++; $display("FAIL rst_first_tick: got %0d want 7 cycles after release", n); end
   endtask

   task automatic test_idle();
      int ticks, tick_err, busy_cnt, busy_err;
      logic [N_CH-1:0] db_or;
      ticks = 0; tick_err = 0; busy_cnt = 0; busy_err = 0; db_or = '0;
      ev_acc = '0;
      for (int k = 1; k <= 96; k++) begin
         step();
         if (m_tick === 1'b1) ticks++;
         if (m_tick !== ((k % 8) == 0)) tick_err++;
         if (busy === 1'b1) busy_cnt++;
         if (busy !== (((k - 1) % 8) < 4)) busy_err++;
         db_or = db_or | db;
      end
      n_cmp++; if (ticks !== 12)    begin n_bad++; $display("FAIL idle_ticks: got %0d want 12", ticks); end
      n_cmp++; if (tick_err !== 0)  begin n_bad++; $display("FAIL idle_tick_pos: got %0d bad cycles want 0", tick_err); end
      n_cmp++; if (busy_cnt !== 48) begin n_bad++; $display("FAIL idle_busy_cnt: got %0d want 48", busy_cnt); end
      n_cmp++; if (busy_err !== 0)  begin n_bad++; $display("FAIL idle_busy_pos: got %0d bad cycles want 0", busy_err); end
      n_cmp++; if (db_or !== 4'b0000)  begin n_bad++; $display("FAIL idle_db: got %b want 0000", db_or); end
      n_cmp++; if (ev_acc !== 4'b0000) begin n_bad++; $display("FAIL idle_events: got %b want 0000", ev_acc); end
   endtask

   task automatic test_rise_single();
      steps(5);
      sw = 4'b0100;
      ev_acc = '0;
      wait_tick(); step();
      wait_tick(); step();
      wait_tick();
      steps(3);
      n_cmp++; if (db !== 4'b0000)     begin n_bad++; $display("FAIL rise_db_early: got %b want 0000", db); end
      n_cmp++; if (ev_acc !== 4'b0000) begin n_bad++; $display("FAIL rise_early_ev: got %b want 0000", ev_acc); end
      step();
      n_cmp++; if (db !== 4'b0100) begin n_bad++; $display("FAIL rise_db: got %b want 0100", db); end
      n_cmp++; if (rise !== ({4{EV}} & 4'b0100)) begin n_bad++; $display("FAIL rise_pulse: got %b want %b", rise, {4{EV}} & 4'b0100); end
      n_cmp++; if (fall !== 4'b0000) begin n_bad++; $display("FAIL rise_fall: got %b want 0000", fall); end
      step();
      n_cmp++; if (rise !== 4'b0000) begin n_bad++; $display("FAIL rise_one_cycle: got %b want 0000", rise); end
      n_cmp++; if (db !== 4'b0100)   begin n_bad++; $display("FAIL rise_db_hold: got %b want 0100", db); end
   endtask

   task automatic test_glitch();
      sw = 4'b0110;
      ev_acc = '0;
      wait_tick(); step();
      wait_tick(); steps(5);
      sw = 4'b0100;
      wait_tick(); steps(6);
      n_cmp++; if (db !== 4'b0100)     begin n_bad++; $display("FAIL glitch_db: got %b want 0100", db); end
      n_cmp++; if (ev_acc !== 4'b0000) begin n_bad++; $display("FAIL glitch_ev: got %b want 0000", ev_acc); end
      sw = 4'b0110;
      wait_tick(); step();
      wait_tick(); steps(5);
      n_cmp++; if (db !== 4'b0100) begin n_bad++; $display("FAIL glitch_cnt_cleared: got %b want 0100", db); end
      sw = 4'b0100;
      wait_tick(); steps(5);
      n_cmp++; if (ev_acc !== 4'b0000) begin n_bad++; $display("FAIL glitch_ev2: got %b want 0000", ev_acc); end
   endtask

   task automatic test_all_channels();
      logic [N_CH-1:0] exp_db [6];
      logic [N_CH-1:0] exp_ev [6];
      sw = 4'b1111;
      do_reset();
      exp_db = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1111};
      exp_ev = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
      wait_tick(); step();
      wait_tick(); step();
      wait_tick();
      for (int k = 0; k < 6; k++) begin
         step();
         n_cmp++; if (db !== exp_db[k]) begin n_bad++; $display("FAIL all_rise_db[%0d]: got %b want %b", k, db, exp_db[k]); end
         n_cmp++; if (rise !== ({4{EV}} & exp_ev[k])) begin n_bad++; $display("FAIL all_rise_pulse[%0d]: got %b want %b", k, rise, {4{EV}} & exp_ev[k]); end
         n_cmp++; if (fall !== 4'b0000) begin n_bad++; $display("FAIL all_rise_fall[%0d]: got %b want 0000", k, fall); end
      end
      sw = 4'b0000;
      exp_db = '{4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b0000};
      wait_tick(); step();
      wait_tick(); step();
      wait_tick();
      for (int k = 0; k < 6; k++) begin
         step();
         n_cmp++; if (db !== exp_db[k]) begin n_bad++; $display("FAIL all_fall_db[%0d]: got %b want %b", k, db, exp_db[k]); end
         n_cmp++; if (fall !== ({4{EV}} & exp_ev[k])) begin n_bad++; $display("FAIL all_fall_pulse[%0d]: got %b want %b", k, fall, {4{EV}} & exp_ev[k]); end
         n_cmp++; if (rise !== 4'b0000) begin n_bad++; $display("FAIL all_fall_rise[%0d]: got %b want 0000", k, rise); end
      end
   endtask

   task automatic test_reset_mid_scan();
      int n;
      sw = 4'b1100;
      ev_acc = '0;
      wait_tick(); step();
      wait_tick(); step();
      wait_tick();
      steps(3);
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy: got %b want 1", busy); end
      reset = 1'b1;
      step();
      reset = 1'b0;
      n_cmp++; if (db !== 4'b0000)  begin n_bad++; $display("FAIL mid_db: got %b want 0000", db); end
      n_cmp++; if (busy !== 1'b0)   begin n_bad++; $display("FAIL mid_busy_clr: got %b want 0", busy); end
      n_cmp++; if (ev_acc !== 4'b0000) begin n_bad++; $display("FAIL mid_ev: got %b want 0000", ev_acc); end
      n = 0;
      while (m_tick !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      n_cmp++; if (n !== 7) begin n_bad++; $display("FAIL mid_next_tick: got %0d want 7 cycles after release", n); end
      steps(5);
      n_cmp++; if (db !== 4'b0000) begin n_bad++; $display("FAIL mid_cnt_cleared: got %b want 0000", db); end
   endtask

   initial begin
      n_cmp  = 0;
      n_bad  = 0;
      ev_acc = '0;
      reset  = 1'b1;
      sw     = '0;
      test_reset();
      test_idle();
      test_rise_single();
      test_glitch();
      test_all_channels();
      test_reset_mid_scan();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion by 200000, want finish");
      $fatal(1, "timeout");
   end

endmodule
